// File: rtl/mips_pkg.sv
// mips_pkg: ALUControl codes, execution FSM states and datapath width default
package mips_pkg;
   localparam int WIDTH_DEF = 32;
   localparam logic [4:0] ALU_SLL  = 5'b00000;
   localparam logic [4:0] ALU_SRL  = 5'b00001;
   localparam logic [4:0] ALU_SRA  = 5'b00010;
   localparam logic [4:0] ALU_SLLV = 5'b00011;
   localparam logic [4:0] ALU_SRLV = 5'b00100;
   localparam logic [4:0] ALU_SRAV = 5'b00101;
   localparam logic [4:0] ALU_ADD  = 5'b00110;
   localparam logic [4:0] ALU_SUB  = 5'b00111;
   localparam logic [4:0] ALU_AND  = 5'b01000;
   localparam logic [4:0] ALU_OR   = 5'b01001;
   localparam logic [4:0] ALU_XOR  = 5'b01010;
   localparam logic [4:0] ALU_NOR  = 5'b01011;
   localparam logic [4:0] ALU_SLT  = 5'b01100;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle add/sub/logic/slt with signed overflow
module alu_comb
   import mips_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       ctl,
   output logic [WIDTH-1:0] y,
   output logic             ov
);
   logic             sub, arith;
   logic [WIDTH-1:0] bx, sum;
   always_comb begin
      sub   = ctl == ALU_SUB;
      arith = !(ctl inside {ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT});
      bx    = sub ? ~b : b;
      sum   = a + bx + {{(WIDTH-1){1'b0}}, sub};
      // sign compare rather than the sum's sign, so SLT stays right on overflow
      y     = ctl == ALU_AND ? a & b :
              ctl == ALU_OR  ? a | b :
              ctl == ALU_XOR ? a ^ b :
              ctl == ALU_NOR ? ~(a | b) :
              ctl == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} : sum;
      ov    = arith && (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU with one-cycle arithmetic and bit-serial shifts
module alu_exec_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [4:0]                 alu_control,
   input  logic [WIDTH-1:0]           src_a,
   input  logic [WIDTH-1:0]           src_b,
   input  logic [$clog2(WIDTH)-1:0]   shamt,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           result,
   output logic                       zero,
   output logic                       overflow
);
   localparam int SHAMT_W = $clog2(WIDTH);
   logic [1:0]         state;
   logic [SHAMT_W-1:0] cnt, amt;
   logic               left, fill, is_shift, is_var;
   logic [WIDTH-1:0]   y, shn, first;
   logic               ov;
   alu_comb #(.WIDTH(WIDTH)) u_comb (.a(src_a), .b(src_b), .ctl(alu_control), .y(y), .ov(ov));
   always_comb begin
      is_shift  = alu_control <= ALU_SRAV;
      is_var    = alu_control inside {ALU_SLLV, ALU_SRLV, ALU_SRAV};
      amt       = is_var ? src_a[SHAMT_W-1:0] : shamt;
      first     = is_shift ? src_b : y;
      shn       = left ? {result[WIDTH-2:0], 1'b0} : {fill, result[WIDTH-1:1]};
      in_ready  = state == IDLE;
      out_valid = state == DONE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         cnt      <= '0;
         left     <= 1'b0;
         fill     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               result   <= first;
               zero     <= first == '0;
               overflow <= !is_shift && ov;
               left     <= alu_control inside {ALU_SLL, ALU_SLLV};
               fill     <= (alu_control inside {ALU_SRA, ALU_SRAV}) && src_b[WIDTH-1];
               cnt      <= amt;
               state    <= (is_shift && amt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
               result <= shn;
               zero   <= shn == '0;
               cnt    <= cnt - 1'b1;
               if (cnt == 1) state <= DONE;
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution unit on the consumer side of the 5-bit ALUControl code produced by the ALU control decoder.
- Accepts one operation per valid/ready handshake and computes it.
  - Arithmetic and logic ops complete in one cycle.
  - Shifts run bit-serially, one position per cycle.
- Result and flags are held until the downstream stage takes them.
- Sits between the register-read stage and write-back in the multi-cycle datapath variant.

Parameters:
- WIDTH, 32, datapath width. SHAMT_W = log2(WIDTH) is a derived localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- alu_control  input  5  operation code (encoding below).
- src_a  input  WIDTH  rs operand; bits [SHAMT_W-1:0] give the variable shift amount.
- src_b  input  WIDTH  rt operand; this is the value shifted by all shift ops.
- shamt  input  SHAMT_W  immediate shift amount.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow; meaningful for ADD and SUB only.

Behaviour:
- Encoding:
  - 00000 SLL (shamt), 00001 SRL (shamt), 00010 SRA (shamt).
  - 00011 SLLV, 00100 SRLV, 00101 SRAV (amount from src_a).
  - 00110 ADD, 00111 SUB, 01000 AND, 01001 OR, 01010 XOR, 01011 NOR, 01100 SLT.
  - Every other code executes as ADD.
- Reset: state=IDLE; in_ready=1; out_valid=0; result, zero, overflow=0; shift counter=0. Reset mid-operation aborts the operation with no output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch all operands and the code.
    - Non-shift op, or shift with amount 0: register the result and go to DONE.
    - Otherwise: load the shift register with src_b and the counter with the amount, then go to SHIFT.
  - SHIFT: each cycle, shift 1 position and decrement the counter. When the counter reaches 1, the final shift happens and the state goes to DONE.
    - Left shifts fill with 0. SRL/SRLV fill with 0. SRA/SRAV fill with the original src_b MSB.
  - DONE: out_valid=1; result, zero and overflow are stable. On out_ready, go to IDLE with out_valid=0. in_ready stays 0 until the state is IDLE.
- Latency, with the accept cycle at T:
  - Non-shift op, or amount 0: out_valid rises at T+1.
  - Shift with amount N (1..WIDTH-1): out_valid rises at T+1+N.
- Throughput: no new accept while busy. The next accept is possible one cycle after the output handshake.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operands share a sign and the result sign differs. For SUB, "operands" means src_a and the inverted src_b.
  - SLT = 1 when signed src_a < signed src_b, else 0. It is correct even when src_a-src_b overflows, and its overflow is 0.
  - zero is computed from the final result for every op.
  - overflow is 0 for all ops other than ADD and SUB.
- Amounts:
  - Variable amount is src_a[SHAMT_W-1:0]; upper bits are ignored.
  - Amount 0 returns src_b unchanged.
- Simultaneous events:
  - in_valid asserted during SHIFT or DONE is ignored; the requester holds it.
  - out_ready while out_valid=0 has no effect.
  - Input values are don't-care after the accept cycle, because operands are latched.

Decomposition:
- Shared package mips_pkg holds:
  - the ALUControl code constants, shared with the decoder;
  - the state enumeration;
  - a WIDTH default constant.
- One sub-module, alu_comb: purely combinational ADD/SUB/AND/OR/XOR/NOR/SLT plus overflow.
- Shift sequencing, handshake and the FSM live in alu_exec_unit.

Test Plan:
- ADD: src_a=0x7FFFFFFF, src_b=0x00000001, code 00110 -> result 0x80000000, overflow=1, zero=0, out_valid at T+1.
- SRA: src_b=0xF0000000, shamt=4, code 00010 -> result 0xFF000000 at T+5; in_ready=0 for cycles T+1..T+5; in_valid pulses in that window are ignored.
- SLLV and SRLV:
  - SLLV with src_a=0xFFFFFFE0 (amount 0), src_b=0x12345678 -> result 0x12345678 at T+1.
  - SRLV with src_a=31, src_b=0x80000000 -> result 0x00000001 at T+32.
- SUB/SLT/default code:
  - SUB with src_a=src_b=0x5 -> zero=1, overflow=0.
  - SLT with src_a=0xFFFFFFFF, src_b=0x1 -> result 1.
  - SLT with src_a=0x80000000, src_b=0x7FFFFFFF -> result 1, overflow=0.
  - Code 11111 with 2+3 -> result 5.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> result and flags stay stable. Raise out_ready -> out_valid=0 and in_ready=1 next cycle, and a new accept succeeds.
- Reset: assert rst in the middle of an SLL with shamt=10 -> outputs go to their reset values immediately. After release the unit is in IDLE with in_ready=1, and no stale out_valid appears.
